// File: rtl/servo_angle_ramp_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// servo_angle_ramp_if : command handshake and angle output bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface servo_angle_ramp_if;
  logic       cmd_valid;
  logic [7:0] cmd_angle;
  logic       cmd_ready;
  logic       abort;
  logic [7:0] rotate_angle;
  logic       busy;
  logic       done;

  modport master (
    output cmd_valid, cmd_angle, abort,
    input  cmd_ready, rotate_angle, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_angle, abort,
    output cmd_ready, rotate_angle, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/servo_angle_ramp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// servo_angle_ramp : slews the PWM angle toward a commanded target in steps
// Rev 1.0
// ----------------------------------------------------------------------------
module servo_angle_ramp #(
  parameter int STEP_TICKS = 120_000,
  parameter int STEP_DEG   = 1,
  parameter int MAX_ANGLE  = 179,
  parameter int INIT_ANGLE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  servo_angle_ramp_if.slave    bus
);

  localparam int                CNT_W     = $clog2(STEP_TICKS);
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(STEP_TICKS - 1);
  localparam logic [8:0]        STEP9     = 9'(STEP_DEG);
  localparam logic [7:0]        MAX8      = 8'(MAX_ANGLE);
  localparam logic [7:0]        INIT8     = 8'(INIT_ANGLE);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MOVE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [7:0]       angle_q, angle_d;
  logic [7:0]       target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [7:0]        cmd_sat;
  logic signed [8:0] diff;
  logic [8:0]        mag;
  logic [8:0]        step;
  logic [7:0]        next_angle;

  always_comb begin
    cmd_sat = (bus.cmd_angle > MAX8) ? MAX8 : bus.cmd_angle;

    // Step is clamped to the remaining distance, so the target is never overshot
    diff       = $signed({1'b0, target_q}) - $signed({1'b0, angle_q});
    mag        = diff[8] ? 9'(-diff) : 9'(diff);
    step       = (mag < STEP9) ? mag : STEP9;
    next_angle = diff[8] ? (angle_q - step[7:0]) : (angle_q + step[7:0]);
  end

  always_comb begin
    state_d  = state_q;
    angle_d  = angle_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          target_d = cmd_sat;
          if (cmd_sat == angle_q) begin
            done_d = 1'b1;
          end else begin
            state_d = S_MOVE;
            busy_d  = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      S_MOVE: begin
        if (bus.abort) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          cnt_d    = '0;
          target_d = angle_q;
        end else if (cnt_q == TICK_LAST) begin
          cnt_d   = '0;
          angle_d = next_angle;
          if (next_angle == target_q) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      angle_q  <= INIT8;
      target_q <= INIT8;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      angle_q  <= angle_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.cmd_ready    = (state_q == S_IDLE);
  assign bus.rotate_angle = angle_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule
`default_nettype wire
